// File: rtl/mux_mult_pkg.sv
// Shared types and sizing helpers for the iterative shift-add multiplier.
package mux_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width, $clog2(WIDTH); kept at least one bit wide.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mux_mult_row.sv
// One row of multiplier cells: a ripple of full adders forming acc_hi +/- mcand.
// With MUX_MULT_SEQ_SIGNED_EN the top sum bit is the true sign of a WIDTH+1-bit result.
module mux_mult_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] mcand,
  input  logic             sel,
  input  logic             sub,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH-1:0] addend;
  logic             carry;

  always_comb begin
    addend = '0;
    if (sel) begin
      addend = sub ? ~mcand : mcand;
    end
    // Subtraction is ~mcand with a carry-in of one.
    carry = sel & sub;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = acc_hi[i] ^ addend[i] ^ carry;
      carry  = (acc_hi[i] & addend[i]) | (carry & (acc_hi[i] ^ addend[i]));
    end
`ifdef MUX_MULT_SEQ_SIGNED_EN
    sum[WIDTH] = acc_hi[WIDTH-1] ^ addend[WIDTH-1] ^ carry;
`else
    sum[WIDTH] = carry;
`endif
  end

endmodule

// File: rtl/mux_mult_seq.sv
// Iterative shift-add multiplier: one row of cells reused for WIDTH cycles.
// Define MUX_MULT_SEQ_SIGNED_EN for two's complement operands and product.
module mux_mult_seq
  import mux_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] mreg_q,   mreg_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH:0]   row_sum;
  logic             last_iter;
  logic             row_sub;

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MUX_MULT_SEQ_SIGNED_EN
  // The multiplier's MSB carries negative weight, so its partial product is subtracted.
  assign row_sub = last_iter & mreg_q[0];
`else
  assign row_sub = 1'b0;
`endif

  mux_mult_row #(
    .WIDTH (WIDTH)
  ) u_row (
    .acc_hi (acc_hi_q),
    .mcand  (mcand_q),
    .sel    (mreg_q[0]),
    .sub    (row_sub),
    .sum    (row_sum)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    mreg_d   = mreg_q;
    mcand_d  = mcand_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = RUN;
          mcand_d  = b;
          mreg_d   = a;
          acc_hi_d = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        // Right shift of {sum, mreg}: sum LSB drops into the multiplier's vacated MSB.
        acc_hi_d = row_sum[WIDTH:1];
        mreg_d   = {row_sum[0], mreg_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      mreg_q   <= '0;
      mcand_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      mreg_q   <= mreg_d;
      mcand_q  <= mcand_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = {acc_hi_q, mreg_q};

endmodule

// File: tb/tb_mux_mult_seq.sv
// Scoreboard bench for mux_mult_seq: driver queues expected products, monitor checks them.
module tb_mux_mult_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  always #5 clk = ~clk;

  mux_mult_seq #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  int             tests   = 0;
  int             fails   = 0;
  int             cyc     = 0;
  int             acc_cyc = 0;
  logic [2*W-1:0] exp_q[$];
  string          name_q[$];
  bit             rnd_on  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic report_timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Present an operand pair, hold it until accepted, queue the expected product.
  task automatic issue(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [2*W-1:0] exp);
    int n = 0;
    @(negedge clk);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      report_timeout({nm, " accept"});
      in_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || !in_ready) report_timeout({nm, " drain"});
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
`ifdef MUX_MULT_SEQ_SIGNED_EN
    logic signed [2*W-1:0] sa, sb;
    sa = {{W{av[W-1]}}, av};
    sb = {{W{bv[W-1]}}, bv};
    return sa * sb;
`else
    logic [2*W-1:0] ua, ub;
    ua = {{W{1'b0}}, av};
    ub = {{W{1'b0}}, bv};
    return ua * ub;
`endif
  endfunction

  // Monitor: latency on rise, stability while stalled, scoreboard compare on handshake.
  logic           prev_v = 1'b0;
  logic [2*W-1:0] hold   = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready low while out_valid", in_ready, 0);
        if (!prev_v) begin
          check("latency accept to out_valid", cyc - acc_cyc, W + 1);
          hold = product;
        end else begin
          check("product stable under backpressure", product, hold);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected out_valid: got product 0x%0h, expected none", product);
          end else begin
            check(name_q.pop_front(), product, exp_q.pop_front());
          end
        end
      end
      prev_v = out_valid & ~out_ready;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset product", product, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    issue("13x11", 8'd13, 8'd11, 16'h008F);
    check("busy after accept", busy, 1);
    check("in_ready after accept", in_ready, 0);
    drain("13x11");
`ifdef MUX_MULT_SEQ_SIGNED_EN
    issue("-3x5", 8'hFD, 8'h05, 16'hFFF1);
    issue("-128x-128", 8'h80, 8'h80, 16'h4000);
    issue("127x-1", 8'h7F, 8'hFF, 16'hFF81);
    issue("-1x-1", 8'hFF, 8'hFF, 16'h0001);
    issue("0xA5 times 0", 8'h00, 8'hA5, 16'h0000);
`else
    issue("255x255", 8'hFF, 8'hFF, 16'hFE01);
    issue("0x0xA5", 8'h00, 8'hA5, 16'h0000);
    issue("1x0x80", 8'h01, 8'h80, 16'h0080);
    issue("128x2", 8'h80, 8'h02, 16'h0100);
`endif
    drain("directed");

    // Backpressure with a second operand pair waiting at the input.
    out_ready = 1'b0;
    fork
      begin
        issue("bp_A 100x3", 8'd100, 8'd3, 16'h012C);
        issue("bp_B 7x9", 8'd7, 8'd9, 16'h003F);
      end
      begin
        int n = 0;
        while (!out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        if (!out_valid) report_timeout("bp out_valid");
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("backpressure");

    // Abort in RUN cycle 4: no product may appear.
    @(negedge clk);
    a        = 8'd50;
    b        = 8'd50;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort in_ready", in_ready, 1);
    check("abort busy", busy, 0);
    check("abort out_valid", out_valid, 0);
    repeat (12) @(negedge clk);
    issue("7x6 after abort", 8'd7, 8'd6, 16'h002A);
    drain("after abort");

    // Short model-checked run with random consumer stalls.
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      issue("random", ra, rb, model(ra, rb));
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain("random");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
